// File: rtl/i2c_reg_target.sv
// I2C target with a byte-wide register file and an auto-incrementing register pointer.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample agreement filter on SCL/SDA after the synchronizers.
module i2c_reg_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         DEPTH       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    output logic                     wr_valid,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_IGNORE, ST_ADDR_ACK, ST_WR_PTR,
        ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK
    } state_t;

    logic          scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic          scl_f_s, sda_f_s, scl_p_q, sda_p_q;
    logic          start_s, stop_s, scl_rise_s, scl_fall_s;
    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [6:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          ack_ph_q, ack_ph_d, rw_q, rw_d;
    logic          sda_oe_q, sda_oe_d, busy_q, busy_d;
    logic          wr_valid_q, wr_valid_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [DEPTH];
    logic [7:0]    rx_byte_s, rd_byte_s;
    logic          addr_hit_s, reg_we_s;

    // Two-flop synchronizers; they reset to the idle bus level so reset creates no edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= scl_i;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= sda_i;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_h_q, sda_h_q;
    logic       scl_flt_q, scl_flt_d, sda_flt_q, sda_flt_d;

    // Filtered level follows the line only once three consecutive samples agree
    always_comb begin
        scl_flt_d = scl_flt_q;
        sda_flt_d = sda_flt_q;
        if (scl_s2_q == scl_h_q[0] && scl_s2_q == scl_h_q[1]) scl_flt_d = scl_s2_q;
        else scl_flt_d = scl_flt_q;
        if (sda_s2_q == sda_h_q[0] && sda_s2_q == sda_h_q[1]) sda_flt_d = sda_s2_q;
        else sda_flt_d = sda_flt_q;
    end

    // Filter sample history and filtered levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_h_q   <= 2'b11;
            sda_h_q   <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_h_q   <= {scl_h_q[0], scl_s2_q};
            sda_h_q   <= {sda_h_q[0], sda_s2_q};
            scl_flt_q <= scl_flt_d;
            sda_flt_q <= sda_flt_d;
        end
    end

    assign scl_f_s = scl_flt_q;
    assign sda_f_s = sda_flt_q;
`else
    assign scl_f_s = scl_s2_q;
    assign sda_f_s = sda_s2_q;
`endif

    // Previous conditioned levels for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_p_q <= scl_f_s;
            sda_p_q <= sda_f_s;
        end
    end

    assign start_s    = scl_f_s & scl_p_q & sda_p_q & ~sda_f_s;
    assign stop_s     = scl_f_s & scl_p_q & ~sda_p_q & sda_f_s;
    assign scl_rise_s = scl_f_s & ~scl_p_q;
    assign scl_fall_s = ~scl_f_s & scl_p_q;
    assign rx_byte_s  = {shift_q, sda_f_s};
    assign rd_byte_s  = regs_q[ptr_q];
    assign addr_hit_s = (rx_byte_s[7:1] == TARGET_ADDR);

    // State register plus datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            tx_q       <= 7'd0;
            ptr_q      <= '0;
            ack_ph_q   <= 1'b0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ptr_q      <= ptr_d;
            ack_ph_q   <= ack_ph_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
        end else if (reg_we_s) begin
            regs_q[ptr_q] <= rx_byte_s;
        end else begin
            regs_q[ptr_q] <= regs_q[ptr_q];
        end
    end

    // Next-state: bit shifting, ACK phases (ack_ph=1 means our ACK/read slot is in progress)
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        ack_ph_d  = ack_ph_q;
        rw_d      = rw_q;
        if (start_s) begin
            state_d   = ST_ADDR;
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
        end else if (stop_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            ack_ph_d  = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_WR_PTR, ST_WR_DATA: begin
                    if (scl_rise_s) begin
                        shift_d   = rx_byte_s[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ack_ph_d = 1'b0;
                            if (state_q == ST_ADDR) begin
                                rw_d    = rx_byte_s[0];
                                state_d = addr_hit_s ? ST_ADDR_ACK : ST_IGNORE;
                            end else if (state_q == ST_WR_PTR) begin
                                ptr_d   = rx_byte_s[AW-1:0];
                                state_d = ST_WR_ACK;
                            end else begin
                                ptr_d   = ptr_q + AW'(1);
                                state_d = ST_WR_ACK;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ADDR_ACK, ST_WR_ACK: begin
                    if (scl_fall_s && !ack_ph_q) begin
                        ack_ph_d = 1'b1;
                    end else if (scl_fall_s) begin
                        ack_ph_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                        if (state_q == ST_WR_ACK) begin
                            state_d = ST_WR_DATA;
                        end else if (rw_q) begin
                            state_d = ST_RD_DATA;
                            tx_d    = rd_byte_s[6:0];
                        end else begin
                            state_d = ST_WR_PTR;
                        end
                    end else begin
                        ack_ph_d = ack_ph_q;
                    end
                end
                ST_RD_DATA: begin
                    if (scl_fall_s && bit_cnt_q == 3'd7) begin
                        state_d   = ST_RD_ACK;
                        bit_cnt_d = 3'd0;
                        ack_ph_d  = 1'b0;
                    end else if (scl_fall_s) begin
                        tx_d      = {tx_q[5:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        tx_d = tx_q;
                    end
                end
                ST_RD_ACK: begin
                    if (scl_rise_s && !ack_ph_q) begin
                        ptr_d = ptr_q + AW'(1);
                        if (!sda_f_s) ack_ph_d = 1'b1;
                        else state_d = ST_IGNORE;
                    end else if (scl_fall_s && ack_ph_q) begin
                        state_d   = ST_RD_DATA;
                        tx_d      = rd_byte_s[6:0];
                        ack_ph_d  = 1'b0;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_IDLE, ST_IGNORE: state_d = state_q;
                default:            state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs: SDA drive changes only on a detected SCL fall, except bus events which release it
    always_comb begin
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        reg_we_s   = 1'b0;
        if (state_q == ST_WR_DATA && scl_rise_s && bit_cnt_q == 3'd7) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = rx_byte_s;
            reg_we_s   = 1'b1;
        end else begin
            wr_valid_d = 1'b0;
        end
        if (stop_s) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_s) begin
            sda_oe_d = 1'b0;
        end else if (state_q == ST_ADDR && scl_rise_s && bit_cnt_q == 3'd7 && addr_hit_s) begin
            busy_d = 1'b1;
        end else if (scl_fall_s) begin
            case (state_q)
                ST_ADDR_ACK: sda_oe_d = ack_ph_q ? (rw_q & ~rd_byte_s[7]) : 1'b1;
                ST_WR_ACK:   sda_oe_d = ~ack_ph_q;
                ST_RD_DATA:  sda_oe_d = (bit_cnt_q == 3'd7) ? 1'b0 : ~tx_q[6];
                ST_RD_ACK:   sda_oe_d = ack_ph_q & ~rd_byte_s[7];
                default:     sda_oe_d = 1'b0;
            endcase
        end else begin
            sda_oe_d = sda_oe_q;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = busy_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
endmodule

// File: tb/tb_i2c_reg_target.sv
// Scoreboard bench for i2c_reg_target: a bus master drives SCL/SDA, monitors compare write strobes and bus bytes.
module tb_i2c_reg_target;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        scl_m = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_line;
    logic        sda_oe, wr_valid, busy;
    logic [3:0]  wr_addr;
    logic [7:0]  wr_data;
    int          n_tests = 0;
    int          n_fail = 0;
    int          oe_cnt = 0;
    int          busy_cnt = 0;

    typedef struct { string name; logic [7:0] val; } item_t;
    item_t       bus_exp_q[$];
    item_t       bus_act_q[$];
    logic [11:0] wr_exp_q[$];

    assign sda_line = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_reg_target #(.TARGET_ADDR(7'h42), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write-strobe monitor and activity counters
    always @(negedge clk) begin
        logic [11:0] e;
        if (sda_oe) oe_cnt++;
        if (busy) busy_cnt++;
        if (wr_valid) begin
            if (wr_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
            end else begin
                e = wr_exp_q.pop_front();
                chk("wr_event", {20'd0, wr_addr, wr_data}, {20'd0, e});
            end
        end
    end

    // Bus byte/ACK monitor
    always @(negedge clk) begin
        item_t a;
        item_t e;
        if (bus_act_q.size() > 0) begin
            a = bus_act_q.pop_front();
            if (bus_exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected nothing", a.name, a.val);
            end else begin
                e = bus_exp_q.pop_front();
                chk(e.name, {24'd0, a.val}, {24'd0, e.val});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (10) @(posedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_rstart();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic wbit(input logic b);
        sda_m = b; wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        @(negedge clk) b = sda_line;
        wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic wbyte(input logic [7:0] d, input logic exp_ack, input string nm);
        item_t it;
        logic  a;
        it.name = nm;
        it.val  = {7'd0, exp_ack};
        bus_exp_q.push_back(it);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        it.val = {7'd0, a};
        bus_act_q.push_back(it);
    endtask

    task automatic rbyte(input logic [7:0] exp, input logic nack, input string nm);
        item_t      it;
        logic [7:0] d;
        logic       b;
        it.name = nm;
        it.val  = exp;
        bus_exp_q.push_back(it);
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
        it.val = d;
        bus_act_q.push_back(it);
    endtask

    initial begin
        logic b;
        int   oe_base;
        int   busy_base;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Write burst to reg3/reg4
        i2c_start();
        wbyte(8'h84, 1'b0, "wb_addr_ack");
        @(negedge clk) chk("wb_busy_high", {31'd0, busy}, 32'd1);
        wbyte(8'h03, 1'b0, "wb_ptr_ack");
        wr_exp_q.push_back({4'd3, 8'hA5});
        wbyte(8'hA5, 1'b0, "wb_d0_ack");
        wr_exp_q.push_back({4'd4, 8'h5A});
        wbyte(8'h5A, 1'b0, "wb_d1_ack");
        i2c_stop();
        @(negedge clk) chk("wb_busy_low", {31'd0, busy}, 32'd0);

        // Read back with repeated START
        i2c_start();
        wbyte(8'h84, 1'b0, "rd_addr_w_ack");
        wbyte(8'h03, 1'b0, "rd_ptr_ack");
        i2c_rstart();
        wbyte(8'h85, 1'b0, "rd_addr_r_ack");
        rbyte(8'hA5, 1'b0, "rd_byte0");
        rbyte(8'h5A, 1'b1, "rd_byte1");
        @(negedge clk) chk("rd_oe_after_nack", {31'd0, sda_oe}, 32'd0);
        i2c_stop();

        // Address mismatch: target stays silent
        oe_base = oe_cnt;
        busy_base = busy_cnt;
        i2c_start();
        wbyte(8'h90, 1'b1, "mm_addr_nack");
        wbyte(8'h11, 1'b1, "mm_data_nack");
        i2c_stop();
        chk("mm_no_oe", oe_cnt - oe_base, 32'd0);
        chk("mm_no_busy", busy_cnt - busy_base, 32'd0);

        // One-clock SDA glitch while SCL high
        @(posedge clk) sda_m = 1'b0;
        @(posedge clk) sda_m = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("gl_busy", {31'd0, busy}, 32'd0);
        chk("gl_oe", {31'd0, sda_oe}, 32'd0);

        // Pointer wrap-around, then truncated pointer byte
        i2c_start();
        wbyte(8'h84, 1'b0, "wr_addr_ack");
        wbyte(8'h0F, 1'b0, "wr_ptr_ack");
        wr_exp_q.push_back({4'd15, 8'h11});
        wbyte(8'h11, 1'b0, "wr_d0_ack");
        wr_exp_q.push_back({4'd0, 8'h22});
        wbyte(8'h22, 1'b0, "wr_d1_ack");
        wr_exp_q.push_back({4'd1, 8'h33});
        wbyte(8'h33, 1'b0, "wr_d2_ack");
        i2c_stop();
        i2c_start();
        wbyte(8'h84, 1'b0, "tr_addr_w_ack");
        wbyte(8'h21, 1'b0, "tr_ptr_ack");
        i2c_rstart();
        wbyte(8'h85, 1'b0, "tr_addr_r_ack");
        rbyte(8'h33, 1'b1, "tr_reg1");
        i2c_stop();

        // Reset while the target drives a read bit low (reg3 = A5: bit7 high, bit6 low)
        i2c_start();
        wbyte(8'h84, 1'b0, "rs_addr_w_ack");
        wbyte(8'h03, 1'b0, "rs_ptr_ack");
        i2c_rstart();
        wbyte(8'h85, 1'b0, "rs_addr_r_ack");
        rbit(b);
        chk("rs_bit7", {31'd0, b}, 32'd1);
        sda_m = 1'b1;
        wq();
        @(negedge clk) chk("rs_oe_driving", {31'd0, sda_oe}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rs_oe_released", {31'd0, sda_oe}, 32'd0);
        chk("rs_busy_cleared", {31'd0, busy}, 32'd0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        repeat (5) @(posedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        i2c_start();
        wbyte(8'h84, 1'b0, "pr_addr_w_ack");
        wbyte(8'h00, 1'b0, "pr_ptr_ack");
        i2c_rstart();
        wbyte(8'h85, 1'b0, "pr_addr_r_ack");
        for (int i = 0; i < 16; i++) rbyte(8'h00, (i == 15), "pr_reg_zero");
        i2c_stop();

        repeat (50) @(posedge clk);
        chk("wr_queue_drained", wr_exp_q.size(), 32'd0);
        chk("bus_queue_drained", bus_exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
